// File: rtl/dsp_addr_seq.sv
// Burst address sequencer driving the DSP loop counter.
// Emits base + ctr_val per handshake and closes on the counter's end event.
module dsp_addr_seq #(
  parameter int COUNTER_WIDTH = 32,
  parameter int ADDR_WIDTH    = 16,
  parameter int DRAIN_LIMIT   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     abort,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [ADDR_WIDTH-1:0]    cmd_base,
  input  logic [COUNTER_WIDTH-1:0] cmd_length,
  output logic [ADDR_WIDTH-1:0]    addr_out,
  output logic                     addr_valid,
  input  logic                     addr_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic                     ctr_rst,
  output logic                     ctr_load,
  output logic [COUNTER_WIDTH-1:0] ctr_end_val,
  output logic                     ctr_enable,
  input  logic [COUNTER_WIDTH-1:0] ctr_val,
  input  logic                     ctr_event
);

  localparam int DW = $clog2(DRAIN_LIMIT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic [ADDR_WIDTH-1:0]    r_base;
  logic [COUNTER_WIDTH-1:0] r_end;
  logic [DW-1:0]            r_drain;
  logic                     r_err;

  logic w_abort;
  logic w_accept;
  logic w_hs;
  logic w_last;
  logic w_timeout;

  assign w_abort   = abort && (r_state != S_IDLE);
  assign w_accept  = (r_state == S_IDLE) && cmd_valid && !abort;
  assign w_hs      = (r_state == S_RUN) && addr_ready && !abort;
  assign w_last    = w_hs && (ctr_val == r_end);
  assign w_timeout = (r_state == S_DRAIN) && !ctr_event &&
                     (r_drain == DW'(DRAIN_LIMIT - 1));

  assign busy        = (r_state != S_IDLE);
  assign err         = r_err;
  assign ctr_end_val = r_end;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_base <= '0;
      r_end  <= '0;
    end else if (w_accept) begin
      r_base <= cmd_base;
      r_end  <= cmd_length - 1'b1;
    end
  end

  // Counts cycles spent in DRAIN; cleared whenever DRAIN is left.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_drain <= '0;
    end else if ((r_state == S_DRAIN) && !abort) begin
      r_drain <= r_drain + 1'b1;
    end else begin
      r_drain <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else if (w_timeout && !abort) begin
      r_err <= 1'b1;
    end
  end

  always_comb begin
    w_next     = r_state;
    cmd_ready  = 1'b0;
    addr_valid = 1'b0;
    addr_out   = '0;
    done       = 1'b0;
    ctr_rst    = 1'b0;
    ctr_load   = 1'b0;
    ctr_enable = 1'b0;
    if (w_abort) begin
      // Realign the counter on the same edge the FSM returns to IDLE.
      w_next  = S_IDLE;
      ctr_rst = 1'b1;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          cmd_ready = !abort;
          if (w_accept) begin
            w_next = (cmd_length == '0) ? S_DONE : S_LOAD;
          end
        end
        S_LOAD: begin
          ctr_rst  = 1'b1;
          ctr_load = 1'b1;
          w_next   = S_RUN;
        end
        S_RUN: begin
          addr_valid = 1'b1;
          addr_out   = r_base + ctr_val[ADDR_WIDTH-1:0];
          ctr_enable = addr_ready;
          if (w_last) begin
            w_next = S_DRAIN;
          end
        end
        S_DRAIN: begin
          ctr_enable = 1'b1;
          if (ctr_event || w_timeout) begin
            w_next = S_DONE;
          end
        end
        S_DONE: begin
          done   = 1'b1;
          w_next = S_IDLE;
        end
        default: begin
          w_next = S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_addr_seq.sv
// Directed bench for dsp_addr_seq with a behavioural loop-counter model.
// Each task drives one scenario and checks outputs 1ns after the edge.
module tb_dsp_addr_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        abort = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_base = '0;
  logic [31:0] cmd_length = '0;
  logic [15:0] addr_out;
  logic        addr_valid;
  logic        addr_ready = 1'b0;
  logic        busy;
  logic        done;
  logic        err;
  logic        ctr_rst;
  logic        ctr_load;
  logic [31:0] ctr_end_val;
  logic        ctr_enable;
  logic [31:0] ctr_val;
  logic        ctr_event;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_val = '0;
  logic [31:0] m_end = '0;
  logic        m_p0 = 1'b0;
  logic        m_p1 = 1'b0;
  logic        ev_kill = 1'b0;

  logic        stall_rdy [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [15:0] stall_exp [5] = '{16'h0010, 16'h0011, 16'h0011,
                                 16'h0011, 16'h0012};
  logic [15:0] wrap_exp  [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};

  always #5 clk = ~clk;

  dsp_addr_seq #(
    .COUNTER_WIDTH(32),
    .ADDR_WIDTH(16),
    .DRAIN_LIMIT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .abort(abort),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_base(cmd_base),
    .cmd_length(cmd_length),
    .addr_out(addr_out),
    .addr_valid(addr_valid),
    .addr_ready(addr_ready),
    .busy(busy),
    .done(done),
    .err(err),
    .ctr_rst(ctr_rst),
    .ctr_load(ctr_load),
    .ctr_end_val(ctr_end_val),
    .ctr_enable(ctr_enable),
    .ctr_val(ctr_val),
    .ctr_event(ctr_event)
  );

  // Loop counter: wraps at end value, end event delayed by two enabled cycles.
  always @(posedge clk) begin
    if (ctr_load) m_end <= ctr_end_val;
    if (ctr_rst) begin
      m_val <= '0;
      m_p0  <= 1'b0;
      m_p1  <= 1'b0;
    end else if (ctr_enable) begin
      m_p0  <= (m_val == m_end);
      m_p1  <= m_p0;
      m_val <= (m_val == m_end) ? '0 : m_val + 1;
    end
  end

  assign ctr_val   = m_val;
  assign ctr_event = m_p1 & ~ev_kill;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [15:0] b, input logic [31:0] l);
    cmd_valid  = 1'b1;
    cmd_base   = b;
    cmd_length = l;
    tick();
    cmd_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({cmd_ready, addr_valid, busy, done, err, ctr_rst, ctr_load,
         ctr_enable} !== 8'b1000_0000) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 10000000",
               {cmd_ready, addr_valid, busy, done, err, ctr_rst, ctr_load,
                ctr_enable});
    end
    n_cmp++;
    if ({ctr_end_val, addr_out} !== 48'h0) begin
      n_bad++;
      $display("FAIL reset_values: end %h addr %h want 0", ctr_end_val,
               addr_out);
    end
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    addr_ready = 1'b1;
    #1;
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_ready: got %b want 1", cmd_ready);
    end
    send_cmd(16'h0100, 32'd4);
    n_cmp++;
    if ({ctr_rst, ctr_load, ctr_enable, addr_valid, busy} !== 5'b11001) begin
      n_bad++;
      $display("FAIL basic_load: got %b want 11001",
               {ctr_rst, ctr_load, ctr_enable, addr_valid, busy});
    end
    n_cmp++;
    if (ctr_end_val !== 32'd3) begin
      n_bad++;
      $display("FAIL basic_endval: got %0d want 3", ctr_end_val);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if ({addr_valid, ctr_enable, addr_out} !==
          {2'b11, 16'(16'h0100 + i)}) begin
        n_bad++;
        $display("FAIL basic_addr%0d: got v%b e%b %h want v1 e1 %h", i,
                 addr_valid, ctr_enable, addr_out, 16'(16'h0100 + i));
      end
    end
    tick();
    n_cmp++;
    if ({addr_valid, ctr_enable, done, busy} !== 4'b0101) begin
      n_bad++;
      $display("FAIL basic_drain: got %b want 0101",
               {addr_valid, ctr_enable, done, busy});
    end
    tick();
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_early_done: got %b want 0", done);
    end
    tick();
    n_cmp++;
    if ({done, err, ctr_enable} !== 3'b100) begin
      n_bad++;
      $display("FAIL basic_done: got %b want 100", {done, err, ctr_enable});
    end
    tick();
    n_cmp++;
    if ({cmd_ready, busy, done} !== 3'b100) begin
      n_bad++;
      $display("FAIL basic_idle: got %b want 100", {cmd_ready, busy, done});
    end
  endtask

  task automatic test_stall();
    int hs = 0;
    addr_ready = 1'b1;
    send_cmd(16'h0010, 32'd3);
    for (int i = 0; i < 5; i++) begin
      tick();
      addr_ready = stall_rdy[i];
      #1;
      n_cmp++;
      if ({addr_valid, ctr_enable, addr_out} !==
          {1'b1, stall_rdy[i], stall_exp[i]}) begin
        n_bad++;
        $display("FAIL stall_cyc%0d: got v%b e%b %h want v1 e%b %h", i,
                 addr_valid, ctr_enable, addr_out, stall_rdy[i],
                 stall_exp[i]);
      end
      if (addr_valid && addr_ready) hs++;
    end
    addr_ready = 1'b1;
    tick();
    if (addr_valid && addr_ready) hs++;
    n_cmp++;
    if (hs !== 3) begin
      n_bad++;
      $display("FAIL stall_handshakes: got %0d want 3", hs);
    end
    tick();
    tick();
    n_cmp++;
    if (done !== 1'b1) begin
      n_bad++;
      $display("FAIL stall_done: got %b want 1", done);
    end
    tick();
  endtask

  task automatic test_zero();
    addr_ready = 1'b1;
    send_cmd(16'h0055, 32'd0);
    n_cmp++;
    if ({done, addr_valid, ctr_load, ctr_rst, ctr_enable, busy} !==
        6'b100001) begin
      n_bad++;
      $display("FAIL zero_done: got %b want 100001",
               {done, addr_valid, ctr_load, ctr_rst, ctr_enable, busy});
    end
    tick();
    n_cmp++;
    if ({cmd_ready, busy, done, addr_valid} !== 4'b1000) begin
      n_bad++;
      $display("FAIL zero_idle: got %b want 1000",
               {cmd_ready, busy, done, addr_valid});
    end
  endtask

  task automatic test_wrap();
    addr_ready = 1'b1;
    send_cmd(16'hFFFE, 32'd4);
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if ({addr_valid, addr_out} !== {1'b1, wrap_exp[i]}) begin
        n_bad++;
        $display("FAIL wrap_addr%0d: got v%b %h want v1 %h", i, addr_valid,
                 addr_out, wrap_exp[i]);
      end
    end
    tick();
    tick();
    tick();
    n_cmp++;
    if (done !== 1'b1) begin
      n_bad++;
      $display("FAIL wrap_done: got %b want 1", done);
    end
    tick();
  endtask

  task automatic test_abort();
    addr_ready = 1'b1;
    abort      = 1'b1;
    cmd_valid  = 1'b1;
    cmd_base   = 16'h0999;
    cmd_length = 32'd5;
    #1;
    n_cmp++;
    if (cmd_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_idle_ready: got %b want 0", cmd_ready);
    end
    tick();
    abort     = 1'b0;
    cmd_valid = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_idle_accept: busy %b want 0", busy);
    end
    send_cmd(16'h0200, 32'd8);
    tick();
    tick();
    n_cmp++;
    if (addr_out !== 16'h0201) begin
      n_bad++;
      $display("FAIL abort_addr2: got %h want 0201", addr_out);
    end
    abort = 1'b1;
    #1;
    n_cmp++;
    if ({ctr_rst, done} !== 2'b10) begin
      n_bad++;
      $display("FAIL abort_rst: got %b want 10", {ctr_rst, done});
    end
    tick();
    abort = 1'b0;
    #1;
    n_cmp++;
    if ({busy, ctr_rst, done, cmd_ready} !== 4'b0001) begin
      n_bad++;
      $display("FAIL abort_idle: got %b want 0001",
               {busy, ctr_rst, done, cmd_ready});
    end
    send_cmd(16'h0300, 32'd2);
    tick();
    n_cmp++;
    if ({addr_valid, addr_out} !== {1'b1, 16'h0300}) begin
      n_bad++;
      $display("FAIL abort_next0: got v%b %h want v1 0300", addr_valid,
               addr_out);
    end
    tick();
    n_cmp++;
    if ({addr_valid, addr_out} !== {1'b1, 16'h0301}) begin
      n_bad++;
      $display("FAIL abort_next1: got v%b %h want v1 0301", addr_valid,
               addr_out);
    end
    tick();
    tick();
    tick();
    n_cmp++;
    if ({done, err} !== 2'b10) begin
      n_bad++;
      $display("FAIL abort_next_done: got %b want 10", {done, err});
    end
    tick();
  endtask

  task automatic test_err();
    addr_ready = 1'b1;
    ev_kill    = 1'b1;
    send_cmd(16'h0040, 32'd1);
    tick();
    n_cmp++;
    if ({addr_valid, addr_out} !== {1'b1, 16'h0040}) begin
      n_bad++;
      $display("FAIL err_addr: got v%b %h want v1 0040", addr_valid,
               addr_out);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if ({busy, done, err, addr_valid} !== 4'b1000) begin
        n_bad++;
        $display("FAIL err_drain%0d: got %b want 1000", i,
                 {busy, done, err, addr_valid});
      end
    end
    tick();
    n_cmp++;
    if ({done, err} !== 2'b11) begin
      n_bad++;
      $display("FAIL err_done: got %b want 11", {done, err});
    end
    tick();
    n_cmp++;
    if ({busy, done, err} !== 3'b001) begin
      n_bad++;
      $display("FAIL err_sticky: got %b want 001", {busy, done, err});
    end
    ev_kill = 1'b0;
    send_cmd(16'h0000, 32'd0);
    n_cmp++;
    if ({done, err} !== 2'b11) begin
      n_bad++;
      $display("FAIL err_sticky2: got %b want 11", {done, err});
    end
    tick();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (err !== 1'b0) begin
      n_bad++;
      $display("FAIL err_clear: got %b want 0", err);
    end
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached, want normal finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_zero();
    test_wrap();
    test_abort();
    test_err();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
